serial_pe_feeder: RTL and testbench
===================================

SERIAL_PE_FEEDER -- requirements
Module: serial_pe_feeder

Interface
REQ-001 Parameter NAW, default 8: neuron RAM address width.
REQ-002 Parameter WAW, default 16: weight RAM address width.
REQ-003 Parameter RAW, default 8: result buffer address width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset: rst_n, asynchronous, active-low; clock clk.
REQ-006 start  input  1  single-cycle job request, sampled only in IDLE.
REQ-007 vec_len  input  8  MAC beats per output (N); sampled with start.
REQ-008 out_num  input  8  outputs per job (M); sampled with start.
REQ-009 nram_rd / nram_addr  output  1 / NAW  neuron RAM read strobe / address.
REQ-010 nram_data  input  16  neuron RAM read data, valid exactly 1 cycle after nram_rd.
REQ-011 wram_rd / wram_addr  output  1 / WAW  weight RAM read strobe / address.
REQ-012 wram_data  input  16  weight RAM read data, valid exactly 1 cycle after wram_rd.
REQ-013 pe_neuron / pe_weight  output  16 / 16  operands to serial PE, combinationally equal to nram_data / wram_data.
REQ-014 pe_ctl  output  2  bit0 = first beat of an output (clear psum), bit1 = last beat of an output.
REQ-015 pe_vld  output  1  operand-valid strobe to serial PE.
REQ-016 pe_result  input  32  PE partial-sum register value.
REQ-017 pe_vld_o  input  1  PE result-valid, asserted 1 cycle after a beat with pe_ctl[1]=1.
REQ-018 res_we / res_addr / res_data  output  1 / RAW / 32  result buffer write port.
REQ-019 busy  output  1  high in any state other than IDLE.
REQ-020 done  output  1  one-cycle pulse at job completion.

Function
REQ-021 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with N>=1 and M>=1; RUN->DRAIN after last read issued; DRAIN->DONE after M-th res_we; DONE->IDLE unconditionally.
REQ-022 start with N=0 or M=0: IDLE->DONE, no RAM reads, no PE beats, no writes.
REQ-023 start while busy is ignored; vec_len/out_num changes while busy have no effect.
REQ-024 RUN issues one read pair per cycle, no bubbles, for beat i (0..N-1) of output o (0..M-1), o-major order: nram_addr=i, wram_addr=o*N+i (truncated to WAW bits), nram_rd=wram_rd=1.
REQ-025 pe_vld and pe_ctl are registered from the issue cycle: one cycle after issuing beat (i,o), pe_vld=1, pe_ctl[0]=(i==0), pe_ctl[1]=(i==N-1).
REQ-026 N=1: every beat carries pe_ctl=2'b11.
REQ-027 Last beat of output o and first beat of output o+1 are issued in consecutive cycles; no idle cycle between outputs.
REQ-028 res_we = pe_vld_o while busy; res_data = pe_result in that cycle; res_addr = number of results already written in this job (0..M-1).
REQ-029 pe_vld_o while IDLE is ignored (no write).
REQ-030 Job latency: start sampled at edge 0 -> reads in cycles 1..N*M, pe_vld in cycles 2..N*M+1, final res_we in cycle N*M+2, done in cycle N*M+3.
REQ-031 nram_rd, wram_rd, pe_vld, res_we, done are 0 in every cycle not listed above.

Reset
REQ-032 rst_n low, at any time including mid-job: state IDLE, counters 0, busy=0, done=0, nram_rd=wram_rd=0, pe_vld=0, pe_ctl=2'b00, res_we=0, res_addr=0, all addresses 0.
REQ-033 After rst_n deasserts, the first start begins a fresh job; no beats or writes from the aborted job appear.

Verification
REQ-034 N=4, M=2, RAM neuron=[1,2,3,4], weights=[1,1,1,1,2,0,-1,3], behavioural PE model -> res_we cycles 6 and 10, res_data 10 then 11 at addr 0,1, done cycle 11.
REQ-035 N=1, M=3 -> pe_ctl=2'b11 on three consecutive beats, three consecutive res_we, addresses 0,1,2.
REQ-036 N=0, M=5 start -> done in cycle 1, zero reads, zero pe_vld, zero res_we.
REQ-037 start pulsed again in cycle 3 of an N=4,M=2 job -> ignored; exactly 2 writes, single done.
REQ-038 rst_n asserted in cycle 5 of an N=4,M=2 job -> all outputs at reset values immediately; new job after release produces correct results with res_addr starting at 0.
REQ-039 N=255, M=255 -> wram_addr reaches 65024, pe_vld continuous for 65025 cycles, done in cycle 65028.

Source files
------------

// File: rtl/serial_pe_feeder_if.sv
// serial_pe_feeder_if -- bundles the job-control, neuron/weight RAM read,
// serial PE and result-buffer signals of serial_pe_feeder.
//   master : the feeder side (drives RAM reads, PE operands, result writes)
//   slave  : the environment side (RAMs, PE, result buffer, job requester)
// Signal names match the original flat port list one-for-one.
interface serial_pe_feeder_if #(
  parameter int NAW = 8,
  parameter int WAW = 16,
  parameter int RAW = 8
);
  // job control
  logic           start;
  logic [7:0]     vec_len;
  logic [7:0]     out_num;
  logic           busy;
  logic           done;
  // neuron RAM
  logic           nram_rd;
  logic [NAW-1:0] nram_addr;
  logic [15:0]    nram_data;
  // weight RAM
  logic           wram_rd;
  logic [WAW-1:0] wram_addr;
  logic [15:0]    wram_data;
  // serial PE
  logic [15:0]    pe_neuron;
  logic [15:0]    pe_weight;
  logic [1:0]     pe_ctl;
  logic           pe_vld;
  logic [31:0]    pe_result;
  logic           pe_vld_o;
  // result buffer
  logic           res_we;
  logic [RAW-1:0] res_addr;
  logic [31:0]    res_data;

  modport master (
    input  start, vec_len, out_num,
    input  nram_data, wram_data, pe_result, pe_vld_o,
    output busy, done,
    output nram_rd, nram_addr, wram_rd, wram_addr,
    output pe_neuron, pe_weight, pe_ctl, pe_vld,
    output res_we, res_addr, res_data
  );

  modport slave (
    output start, vec_len, out_num,
    output nram_data, wram_data, pe_result, pe_vld_o,
    input  busy, done,
    input  nram_rd, nram_addr, wram_rd, wram_addr,
    input  pe_neuron, pe_weight, pe_ctl, pe_vld,
    input  res_we, res_addr, res_data
  );
endinterface

// File: rtl/serial_pe_feeder.sv
// serial_pe_feeder -- sequences a matrix-vector job through a serial PE.
// For each of M outputs it streams N (neuron, weight) read pairs from the
// neuron and weight RAMs, one pair per cycle with no bubbles, tags the PE
// beats with first/last markers, and writes each PE result to the result
// buffer at consecutive addresses starting from 0.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_pe_feeder_if.master
//            start/vec_len(N)/out_num(M) job request, busy, done pulse,
//            nram_rd/nram_addr/nram_data, wram_rd/wram_addr/wram_data,
//            pe_neuron/pe_weight/pe_ctl/pe_vld, pe_result/pe_vld_o,
//            res_we/res_addr/res_data
module serial_pe_feeder #(
  parameter int NAW = 8,
  parameter int WAW = 16,
  parameter int RAW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_pe_feeder_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;

  logic [7:0]     n_q;        // latched N
  logic [7:0]     m_q;        // latched M
  logic [7:0]     beat_q;     // beat index i within current output
  logic [7:0]     out_q;      // output index o
  logic [WAW-1:0] waddr_q;    // o*N+i, kept as a running count
  logic [7:0]     res_cnt_q;  // results written so far in this job
  logic           pe_vld_q;
  logic [1:0]     pe_ctl_q;

  logic issue;
  logic last_beat;
  logic last_out;
  logic res_we;
  logic last_write;
  logic job_empty;

  assign issue      = (state_q == RUN);
  assign last_beat  = (beat_q == n_q - 8'd1);
  assign last_out   = (out_q == m_q - 8'd1);
  assign res_we     = bus.pe_vld_o && (state_q != IDLE);
  assign last_write = res_we && (res_cnt_q == m_q - 8'd1);
  assign job_empty  = (bus.vec_len == 8'd0) || (bus.out_num == 8'd0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = job_empty ? DONE : RUN;
      RUN:     if (last_beat && last_out) state_d = DRAIN;
      DRAIN:   if (last_write) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Job counters. wram_addr = o*N+i in o-major order is simply the number
  // of pairs issued so far, so a single incrementer replaces the multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      m_q       <= '0;
      beat_q    <= '0;
      out_q     <= '0;
      waddr_q   <= '0;
      res_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            n_q       <= bus.vec_len;
            m_q       <= bus.out_num;
            beat_q    <= '0;
            out_q     <= '0;
            waddr_q   <= '0;
            res_cnt_q <= '0;
          end
        end
        RUN: begin
          waddr_q <= waddr_q + WAW'(1);
          if (last_beat) begin
            beat_q <= '0;
            out_q  <= out_q + 8'd1;
          end else begin
            beat_q <= beat_q + 8'd1;
          end
          if (res_we) res_cnt_q <= res_cnt_q + 8'd1;
        end
        DRAIN: begin
          if (res_we) res_cnt_q <= res_cnt_q + 8'd1;
        end
        DONE: begin
          // Clear so res_addr and the address ports sit at 0 between jobs.
          beat_q    <= '0;
          out_q     <= '0;
          waddr_q   <= '0;
          res_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // PE strobes trail the read issue by one cycle, lining up with RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_vld_q <= 1'b0;
      pe_ctl_q <= 2'b00;
    end else begin
      pe_vld_q <= issue;
      pe_ctl_q <= issue ? {last_beat, (beat_q == 8'd0)} : 2'b00;
    end
  end

  assign bus.nram_rd   = issue;
  assign bus.wram_rd   = issue;
  assign bus.nram_addr = issue ? NAW'(beat_q) : '0;
  assign bus.wram_addr = issue ? waddr_q : '0;

  assign bus.pe_neuron = bus.nram_data;
  assign bus.pe_weight = bus.wram_data;
  assign bus.pe_vld    = pe_vld_q;
  assign bus.pe_ctl    = pe_ctl_q;

  assign bus.res_we    = res_we;
  assign bus.res_addr  = RAW'(res_cnt_q);
  assign bus.res_data  = bus.pe_result;

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_pe_feeder.sv
module tb_serial_pe_feeder;

  localparam int NAW = 8;
  localparam int WAW = 16;
  localparam int RAW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_pe_feeder_if #(.NAW(NAW), .WAW(WAW), .RAW(RAW)) bus ();

  serial_pe_feeder #(.NAW(NAW), .WAW(WAW), .RAW(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- environment models ----------------
  logic [15:0] nmem [0:255];
  logic [15:0] wmem [0:65535];
  logic [31:0] psum;
  logic        vld_o;

  always @(posedge clk) begin
    if (bus.nram_rd) bus.nram_data <= nmem[bus.nram_addr];
    if (bus.wram_rd) bus.wram_data <= wmem[bus.wram_addr];
  end

  // Behavioural serial PE: signed 16x16 MAC, cleared on the first beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum  <= '0;
      vld_o <= 1'b0;
    end else begin
      if (bus.pe_vld)
        psum <= (bus.pe_ctl[0] ? 32'd0 : psum) +
                32'($signed(bus.pe_neuron) * $signed(bus.pe_weight));
      vld_o <= bus.pe_vld && bus.pe_ctl[1];
    end
  end
  assign bus.pe_result = psum;
  assign bus.pe_vld_o  = vld_o;

  // ---------------- scoreboard ----------------
  typedef struct {
    longint cyc;
    longint a;
    longint b;
  } ev_t;

  ev_t rdq[$];
  ev_t bq[$];
  ev_t wq[$];
  ev_t dq[$];

  int     compared   = 0;
  int     mismatched = 0;
  longint cnt        = 0;
  longint base       = 0;
  logic [31:0] exp_res [0:255];

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected event at cycle count %0d", name, cnt);
  endtask

  // Expected events derive from the job timing: start at edge 0, reads in
  // cycles 1..N*M, beats one cycle later, write of output o at N*(o+1)+2,
  // done at N*M+3 (or cycle 1 for an empty job).
  task automatic push_job(input int n, input int m);
    ev_t e;
    if (n == 0 || m == 0) begin
      e.cyc = base + 1; e.a = 0; e.b = 0; dq.push_back(e);
      return;
    end
    for (int o = 0; o < m; o++) begin
      for (int i = 0; i < n; i++) begin
        e.cyc = base + 1 + o*n + i; e.a = i; e.b = (o*n + i) % 65536;
        rdq.push_back(e);
        e.cyc = base + 2 + o*n + i; e.a = (i == n-1) ? 1 : 0; e.b = (i == 0) ? 1 : 0;
        bq.push_back(e);
      end
      e.cyc = base + n*(o+1) + 2; e.a = o; e.b = exp_res[o];
      wq.push_back(e);
    end
    e.cyc = base + n*m + 3; e.a = 0; e.b = 0; dq.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (bus.nram_rd || bus.wram_rd) begin
        if (rdq.size() == 0) unexpected("read");
        else begin
          e = rdq.pop_front();
          chk("rd_cycle", cnt, e.cyc);
          chk("rd_pair", longint'(bus.wram_rd), longint'(bus.nram_rd));
          chk("nram_addr", longint'(bus.nram_addr), e.a);
          chk("wram_addr", longint'(bus.wram_addr), e.b);
        end
      end
      if (bus.pe_vld) begin
        if (bq.size() == 0) unexpected("pe_vld");
        else begin
          e = bq.pop_front();
          chk("beat_cycle", cnt, e.cyc);
          chk("pe_ctl", longint'(bus.pe_ctl), e.a*2 + e.b);
        end
      end
      if (bus.res_we) begin
        if (wq.size() == 0) unexpected("res_we");
        else begin
          e = wq.pop_front();
          chk("wr_cycle", cnt, e.cyc);
          chk("res_addr", longint'(bus.res_addr), e.a);
          chk("res_data", longint'(bus.res_data), e.b);
        end
      end
      if (bus.done) begin
        if (dq.size() == 0) unexpected("done");
        else begin
          e = dq.pop_front();
          chk("done_cycle", cnt, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_start(input int n, input int m);
    @(negedge clk);
    bus.vec_len = 8'(n);
    bus.out_num = 8'(m);
    bus.start   = 1'b1;
    base        = cnt;
    push_job(n, m);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.vec_len = 8'hAA;   // must be ignored while busy
    bus.out_num = 8'h55;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!bus.done && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) unexpected("done_timeout");
    repeat (4) @(negedge clk);
    chk("queues_empty", longint'(rdq.size() + bq.size() + wq.size() + dq.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      longint'(bus.busy), 0);
    chk({tag, "_done"},      longint'(bus.done), 0);
    chk({tag, "_nram_rd"},   longint'(bus.nram_rd), 0);
    chk({tag, "_wram_rd"},   longint'(bus.wram_rd), 0);
    chk({tag, "_nram_addr"}, longint'(bus.nram_addr), 0);
    chk({tag, "_wram_addr"}, longint'(bus.wram_addr), 0);
    chk({tag, "_pe_vld"},    longint'(bus.pe_vld), 0);
    chk({tag, "_pe_ctl"},    longint'(bus.pe_ctl), 0);
    chk({tag, "_res_we"},    longint'(bus.res_we), 0);
    chk({tag, "_res_addr"},  longint'(bus.res_addr), 0);
  endtask

  task automatic load_job1;
    nmem[0] = 16'd1; nmem[1] = 16'd2; nmem[2] = 16'd3; nmem[3] = 16'd4;
    wmem[0] = 16'd1; wmem[1] = 16'd1; wmem[2] = 16'd1; wmem[3] = 16'd1;
    wmem[4] = 16'd2; wmem[5] = 16'd0; wmem[6] = 16'hFFFF; wmem[7] = 16'd3;
    exp_res[0] = 32'd10;   // 1+2+3+4
    exp_res[1] = 32'd11;   // 2+0-3+12
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.vec_len = '0;
    bus.out_num = '0;
    for (int i = 0; i < 256; i++) nmem[i] = '0;
    for (int i = 0; i < 65536; i++) wmem[i] = '0;
    for (int i = 0; i < 256; i++) exp_res[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=4, M=2 reference job
    load_job1();
    issue_start(4, 2);
    wait_done(40);

    // Second start mid-job must be ignored
    issue_start(4, 2);
    @(negedge clk);           // cycle 2
    @(negedge clk);           // cycle 3
    bus.start = 1'b1; bus.vec_len = 8'd1; bus.out_num = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40);

    // Reset in cycle 5 of a job, then a fresh job
    issue_start(4, 2);
    repeat (4) @(negedge clk);   // cycle 5
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rdq.delete(); bq.delete(); wq.delete(); dq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_start(4, 2);
    wait_done(40);

    // Empty job: N=0, M=5
    issue_start(0, 5);
    wait_done(20);

    // N=1, M=3: every beat is both first and last
    nmem[0] = 16'd5;
    wmem[0] = 16'd2; wmem[1] = 16'd3; wmem[2] = 16'hFFFC;
    exp_res[0] = 32'd10;
    exp_res[1] = 32'd15;
    exp_res[2] = 32'hFFFF_FFEC;  // -20
    issue_start(1, 3);
    wait_done(40);

    // N=255, M=255: full address range, each output sums 255 ones
    for (int i = 0; i < 256; i++) nmem[i] = 16'd1;
    for (int i = 0; i < 65536; i++) wmem[i] = 16'd1;
    for (int i = 0; i < 256; i++) exp_res[i] = 32'd255;
    issue_start(255, 255);
    wait_done(255*255 + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
